alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor of the 8-bit combinational ALU.
- Adds three things the earlier ALU lacks:
  - registered result and flags;
  - a persistent carry flag feeding ADC/SBC;
  - barrel-amount shifts/rotates and an unsigned multiply, both executed iteratively, one step per cycle.
- Sits between the register file and writeback of the CPU datapath.
- Uses a START/BUSY/DONE handshake so the control unit can stall on long operations.

Parameters:
- WIDTH, 8, operand/result width. Must be a power of two, at least 4.
- SHW, $clog2(WIDTH), derived localparam. Width of the shift amount taken from B[SHW-1:0].

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request. Accepted only when BUSY=0.
- OP  input  4  opcode, sampled with START.
- A  input  WIDTH  operand A, sampled with START.
- B  input  WIDTH  operand B or shift amount, sampled with START.
- BUSY  output  1  high from the cycle after acceptance until DONE.
- DONE  output  1  one-cycle pulse. Y and flags update in this same cycle.
- Y  output  WIDTH  registered result. Holds until the next DONE.
- C, V, N, Z  output  1 each  registered flags. Hold until the next DONE.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: state IDLE, BUSY=0, DONE=0, Y=0, C=V=N=Z=0.
  - Reset mid-operation aborts it. No DONE is produced, and stale operands are discarded.
- States:
  - IDLE: START=1 latches OP, A, B and the current C into internal registers.
    - Single-cycle op: go to FIN.
    - Shift/rotate: load cnt=B[SHW-1:0]. If cnt=0 go to FIN, else go to ITER.
    - MUL: load cnt=WIDTH, go to ITER.
  - ITER: BUSY=1. One step per cycle, cnt decrements. At cnt=1 the step completes and the next state is FIN.
  - FIN: DONE=1, BUSY=0. Y and flags are written at the clock edge that enters FIN. Next state is IDLE.
  - A START asserted in FIN is accepted. Back-to-back ops are allowed at one op per 2 cycles minimum.
- START while BUSY=1 is ignored, with no side effects.
- Latency from the START edge to DONE high:
  - 1 cycle for arithmetic/logic ops;
  - 1+amount cycles for shifts;
  - 1+WIDTH cycles for MUL.
- Opcodes (arithmetic is modulo 2^WIDTH):
  - 0000 ADD: Y=A+B. C=carry-out. V=signed overflow.
  - 0001 SUB: Y=A+~B+1. C=carry-out (1 = no borrow). V=signed overflow.
  - 0010 ADC: A+B+Cin.
  - 0011 SBC: A+~B+Cin.
  - Cin is the C flag latched at acceptance.
  - 0100 SHL: logical left by amt. C=last bit shifted out.
  - 0101 SHR: logical right by amt. C=last bit out.
  - 0110 SAR: arithmetic right by amt (MSB replicated). C=last bit out.
  - 0111 ROL: rotate left by amt. C=final Y[0].
  - For all shifts and rotates, amt=0 gives Y=A, C=0.
  - 1000 AND, 1001 OR, 1010 XOR: C=0, V=0.
  - 1011 NOT: Y=~A, B ignored. C=0, V=0.
  - 1100 MUL: unsigned shift-add, Y=low WIDTH bits of the product. C=1 iff the high half is non-zero. V=0.
  - 1101-1111 reserved: Y=A, C=V=0. Completes in 1 cycle.
- N and Z on every op: N=Y[WIDTH-1], Z=(Y==0). V=0 for every non-add/sub op.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit opcode constants;
  - the state encoding (IDLE, ITER, FIN).
- Natural sub-module alu_seq_iter: the iterative shift/rotate/multiply datapath.
  - Contains the working register, product accumulator and counter.
  - Has load/step inputs and result/carry outputs.
  - The top level keeps the FSM, adder, logic ops and flag registers.

Test Plan:
- WIDTH=8, ADD 0x7F,0x01 -> DONE one cycle after START, Y=0x80, N=1, V=1, C=0, Z=0. Then SUB 0x05,0x05 -> Y=0x00, Z=1, C=1.
- ADD 0xFF,0x01 (Y=0x00, C=1, Z=1), then ADC 0x10,0x20 -> Y=0x31, C=0. Then SBC 0x00,0x01 with C=0 -> Y=0xFE, N=1, C=0.
- SAR A=0x90, B=3 -> BUSY high 3 cycles, DONE at START+4, Y=0xF2, C=0. SHL A=0x81, B=1 -> Y=0x02, C=1. SHR amount 0 -> Y=A, C=0, DONE at +1.
- MUL 0x0F,0x11 -> Y=0xFF, C=0, DONE at START+9. MUL 0x10,0x10 -> Y=0x00, C=1, Z=1.
- START pulsed with a different OP during an active MUL -> ignored. Result matches the original MUL, exactly one DONE.
- RST_N low for one cycle mid-MUL -> immediately Y=0, flags 0, BUSY=0, no DONE. A subsequent AND 0xF0,0x3C -> Y=0x30, C=0, V=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: 4-bit opcode constants and
// the controller state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SAR = 4'b0110;
  localparam logic [3:0] OP_ROL = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Shifts and rotates occupy opcodes 01xx.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op[3:2] == 2'b01);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath for shifts, rotates and the unsigned multiply.
// One bit of shift (or one multiplier bit) is processed per step.
// Ports:
//   clk_i, rst_ni   clock / async active-low reset (counter only)
//   load_i          capture op, operands and iteration count
//   step_i          advance one iteration
//   op_i, a_i, b_i  opcode and operands captured on load
//   res_o, carry_o  result/carry as they will be after the current step
//   last_o          the current step is the final one
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             last_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [WIDTH:0]     psum;
  logic               c_step;

  // work_q holds the shifted operand, or the multiplicand for MUL.
  // prod_q starts as {0, B}; each step adds A into the high half when the
  // current low bit is set, then shifts the whole register right.
  always_comb begin
    work_d = work_q;
    prod_d = prod_q;
    c_step = 1'b0;
    psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
             (prod_q[0] ? {1'b0, work_q} : '0);
    case (op_q)
      OP_SHL: begin
        work_d = {work_q[WIDTH-2:0], 1'b0};
        c_step = work_q[WIDTH-1];
      end
      OP_SHR: begin
        work_d = {1'b0, work_q[WIDTH-1:1]};
        c_step = work_q[0];
      end
      OP_SAR: begin
        work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        c_step = work_q[0];
      end
      OP_ROL: begin
        // The bit rotated out lands in Y[0], which is what C reports.
        work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        c_step = work_q[WIDTH-1];
      end
      OP_MUL: begin
        prod_d = {psum, prod_q[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  assign res_o   = (op_q == OP_MUL) ? prod_d[WIDTH-1:0] : work_d;
  assign carry_o = (op_q == OP_MUL) ? (|prod_d[2*WIDTH-1:WIDTH]) : c_step;
  assign last_o  = (cnt_q == (SHW+1)'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (op_i == OP_MUL) ? CNT_MUL : {1'b0, b_i[SHW-1:0]};
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - (SHW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      op_q   <= op_i;
      work_q <= a_i;
      prod_q <= {{WIDTH{1'b0}}, b_i};
    end else if (step_i) begin
      work_q <= work_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered result/flags, persistent carry for
// ADC/SBC, and iterative shifts/rotates/multiply behind a START/BUSY/DONE
// handshake.
// Ports:
//   CLK, RST_N      clock / async active-low reset
//   START, OP, A, B request and operands (accepted when BUSY=0)
//   BUSY            iterative operation in progress
//   DONE            one-cycle pulse; Y and flags updated in this cycle
//   Y, C, V, N, Z   registered result and flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d, v_q, v_d, n_q, z_q;
  logic             wr, load, step;
  logic [WIDTH-1:0] it_res;
  logic             it_carry, it_last;
  logic [WIDTH-1:0] b_sel, alu_y;
  logic [WIDTH:0]   sum;
  logic             cin, alu_c, alu_v;
  logic             go_iter;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .load_i  (load),
    .step_i  (step),
    .op_i    (OP),
    .a_i     (A),
    .b_i     (B),
    .res_o   (it_res),
    .carry_o (it_carry),
    .last_o  (it_last)
  );

  // Single-cycle ops are evaluated from the live inputs in the accepting
  // cycle; Cin is the C flag held at that moment.
  always_comb begin
    b_sel = ((OP == OP_SUB) || (OP == OP_SBC)) ? ~B : B;
    if (OP == OP_ADD)      cin = 1'b0;
    else if (OP == OP_SUB) cin = 1'b1;
    else                   cin = c_q;
    sum   = {1'b0, A} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin};
    alu_y = A;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (OP)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[WIDTH-1] == b_sel[WIDTH-1]) &&
                (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_y = A & B;
      OP_OR:   alu_y = A | B;
      OP_XOR:  alu_y = A ^ B;
      OP_NOT:  alu_y = ~A;
      // Zero-amount shifts and reserved opcodes pass A through.
      default: ;
    endcase
  end

  assign go_iter = (OP == OP_MUL) ||
                   (is_shift_op(OP) && (B[SHW-1:0] != '0));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wr      = 1'b0;
    y_d     = y_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (START) begin
          if (go_iter) begin
            load    = 1'b1;
            state_d = ST_ITER;
          end else begin
            wr      = 1'b1;
            y_d     = alu_y;
            c_d     = alu_c;
            v_d     = alu_v;
            state_d = ST_FIN;
          end
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (it_last) begin
          wr      = 1'b1;
          y_d     = it_res;
          c_d     = it_carry;
          v_d     = 1'b0;
          state_d = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr) begin
        y_q <= y_d;
        c_q <= c_d;
        v_q <= v_d;
        n_q <= y_d[WIDTH-1];
        z_q <= (y_d == '0);
      end
    end
  end

  assign BUSY = (state_q == ST_ITER);
  assign DONE = (state_q == ST_FIN);
  assign Y    = y_q;
  assign C    = c_q;
  assign V    = v_q;
  assign N    = n_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic [3:0] OP = 4'h0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       BUSY, DONE, C, V, N, Z;
  logic [7:0] Y;

  int tests_run = 0;
  int tests_failed = 0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Y(Y), .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one op, wait for DONE (bounded), check latency, busy cycles,
  // result and {C,V,N,Z}. Returns with the DUT in its DONE cycle.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input int lat, input logic [7:0] ey,
                        input logic [3:0] ecvnz);
    int cycles;
    int busy_cnt;
    START = 1'b1; OP = op; A = a; B = b;
    tick();
    START = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!DONE && cycles < 40) begin
      if (BUSY) busy_cnt++;
      tick();
      cycles++;
    end
    check({tag, ".lat"}, cycles, lat);
    check({tag, ".busy"}, busy_cnt, lat - 1);
    check({tag, ".y"}, Y, ey);
    check({tag, ".cvnz"}, {C, V, N, Z}, ecvnz);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [7:0] y_at;
    logic [3:0] f_at;

    tick();
    tick();
    check("reset", {BUSY, DONE, C, V, N, Z, Y}, 14'h0);
    RST_N = 1'b1;
    tick();

    //                op      A      B     lat  Y      CVNZ
    run_op("add7f",  4'h0, 8'h7F, 8'h01, 1, 8'h80, 4'b0110);
    run_op("sub05",  4'h1, 8'h05, 8'h05, 1, 8'h00, 4'b1001);
    run_op("addff",  4'h0, 8'hFF, 8'h01, 1, 8'h00, 4'b1001);
    run_op("adc",    4'h2, 8'h10, 8'h20, 1, 8'h31, 4'b0000);
    run_op("sbc",    4'h3, 8'h00, 8'h01, 1, 8'hFE, 4'b0010);
    run_op("sar3",   4'h6, 8'h90, 8'h03, 4, 8'hF2, 4'b0010);
    run_op("shl1",   4'h4, 8'h81, 8'h01, 2, 8'h02, 4'b1000);
    run_op("shr0",   4'h5, 8'hA5, 8'h08, 1, 8'hA5, 4'b0010);
    run_op("rol2",   4'h7, 8'hC0, 8'h02, 3, 8'h03, 4'b1000);
    run_op("xor",    4'hA, 8'hFF, 8'h0F, 1, 8'hF0, 4'b0010);
    run_op("not",    4'hB, 8'h00, 8'h55, 1, 8'hFF, 4'b0010);
    run_op("rsvd",   4'hD, 8'h00, 8'hFF, 1, 8'h00, 4'b0001);
    run_op("mul0f",  4'hC, 8'h0F, 8'h11, 9, 8'hFF, 4'b0010);
    run_op("mul10",  4'hC, 8'h10, 8'h10, 9, 8'h00, 4'b1001);
    tick();
    check("done_drop", {BUSY, DONE}, 2'b00);

    // START with a different op while MUL 0x0D*0x0B=0x8F is running.
    START = 1'b1; OP = 4'hC; A = 8'h0D; B = 8'h0B;
    tick();
    START = 1'b0;
    done_cnt = 0; done_at = 0; y_at = 8'h00; f_at = 4'h0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (DONE) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = cyc; y_at = Y; f_at = {C, V, N, Z};
        end
      end
      if (cyc == 3) begin
        START = 1'b1; OP = 4'h0; A = 8'h01; B = 8'h01;
      end else begin
        START = 1'b0;
      end
      tick();
    end
    check("ign.dones", done_cnt, 1);
    check("ign.lat", done_at, 9);
    check("ign.y", y_at, 8'h8F);
    check("ign.cvnz", f_at, 4'b0010);

    // Reset in the middle of a MUL.
    START = 1'b1; OP = 4'hC; A = 8'hFF; B = 8'hFF;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    RST_N = 1'b0;
    #1;
    check("rst.mid", {BUSY, DONE, C, V, N, Z, Y}, 14'h0);
    tick();
    RST_N = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (DONE || BUSY) done_cnt++;
      tick();
    end
    check("rst.quiet", done_cnt, 0);
    run_op("and",    4'h8, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
